mult_seq_ctrl: RTL

//  Sequencer that builds a wide unsigned multiply (OP_W x OP_W) from one 4x4 array_multiplier_4b.

---
 rtl/mult_seq_ctrl_pkg.sv | 8 +
 rtl/array_multiplier_4b.sv | 16 +
 rtl/mult_seq_ctrl.sv | 79 +++++++
 3 files changed

// File: rtl/mult_seq_ctrl_pkg.sv
// mult_seq_ctrl_pkg: FSM encoding and nibble width shared by the sequential multiplier and its array
package mult_seq_ctrl_pkg;
  localparam int NIB_W = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/array_multiplier_4b.sv
// array_multiplier_4b: combinational 4x4 unsigned array multiplier (shift-and-add rows)
module array_multiplier_4b
  import mult_seq_ctrl_pkg::*;
(
  input  logic [NIB_W-1:0]   a,
  input  logic [NIB_W-1:0]   b,
  input  logic               reset_L,
  output logic [2*NIB_W-1:0] p
);
  logic [2*NIB_W-1:0] sum;
  always_comb begin
    sum = '0;
    for (int k = 0; k < NIB_W; k++) sum = sum + (b[k] ? ((2*NIB_W)'(a) << k) : '0);
    p = reset_L ? sum : '0;
  end
endmodule

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: builds an OP_W x OP_W unsigned multiply from one 4x4 array, one nibble pair per cycle,
// with valid/ready handshakes on operands and product.
module mult_seq_ctrl
  import mult_seq_ctrl_pkg::*;
#(
  parameter int N_NIB = 2,
  localparam int OP_W = NIB_W * N_NIB,
  localparam int PW = 2 * OP_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] in_a,
  input  logic [OP_W-1:0] in_b,
  input  logic            abort,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PW-1:0]   out_p,
  output logic            busy
);
  localparam int IW = cnt_w(N_NIB);
  state_t state, state_nx;
  logic started, accept, last_i, last;
  logic [IW-1:0] i, j;
  logic [OP_W-1:0] a_reg, b_reg;
  logic [PW-1:0] acc, acc_nx;
  logic [2*NIB_W-1:0] pp8;
  array_multiplier_4b u_array (
    .a(a_reg[NIB_W*i +: NIB_W]),
    .b(b_reg[NIB_W*j +: NIB_W]),
    .reset_L(1'b1),
    .p(pp8)
  );
  // started keeps in_ready low until the first edge after reset release
  assign in_ready = started && state == IDLE;
  assign accept = in_valid && in_ready && !abort;
  assign last_i = 32'(i) == N_NIB - 1;
  assign last = last_i && 32'(j) == N_NIB - 1;
  assign acc_nx = acc + (PW'(pp8) << (NIB_W * (32'(i) + 32'(j))));
  assign out_valid = state == DONE;
  assign busy = state == CALC || state == DONE;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = accept ? CALC : IDLE;
      CALC: state_nx = abort ? IDLE : (last ? DONE : CALC);
      DONE: state_nx = out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      started <= 1'b0;
      a_reg <= '0;
      b_reg <= '0;
      acc <= '0;
      i <= '0;
      j <= '0;
      out_p <= '0;
    end else begin
      started <= 1'b1;
      if (accept) begin
        a_reg <= in_a;
        b_reg <= in_b;
        acc <= '0;
        i <= '0;
        j <= '0;
      end else if (state == CALC && !abort) begin
        acc <= acc_nx;
        i <= last_i ? '0 : i + IW'(1);
        j <= last_i ? j + IW'(1) : j;
        if (last) out_p <= acc_nx;
      end
    end
endmodule
